// File: rtl/dtw_result_streamer.sv
// ---------------------------------------------------------------------------
// dtw_result_streamer
//
// Pops one DTW result record (query id, reference position, minimum cost)
// from a result FIFO that has a one-cycle registered read latency, and sends
// it as a three-beat AXI4-Stream packet:
//   beat 1 : qid
//   beat 2 : position
//   beat 3 : minval zero-extended to 32 bits (tlast = 1)
// A 32-bit counter tracks completed packets.
//
// Ports
//   clk            clock, rising edge
//   rst            synchronous active-high reset
//   enable         allows a new FIFO pop to start from IDLE
//   clear_count    synchronous clear of results_sent (wins over increment)
//   fifo_rden      FIFO read strobe, one cycle per record
//   fifo_empty     FIFO empty flag
//   fifo_minval    popped minimum cost   (valid the cycle after fifo_rden)
//   fifo_position  popped ref position   (valid the cycle after fifo_rden)
//   fifo_qid       popped query id       (valid the cycle after fifo_rden)
//   m_axis_tdata   stream data
//   m_axis_tvalid  stream valid
//   m_axis_tready  stream ready
//   m_axis_tlast   last beat of a packet
//   busy           high in every state except IDLE
//   results_sent   number of completed packets (wraps at 2^32)
// ---------------------------------------------------------------------------
module dtw_result_streamer #(
    parameter int DTW_DWIDTH = 16,
    parameter int AXI_DWIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  clear_count,
    output logic                  fifo_rden,
    input  logic                  fifo_empty,
    input  logic [DTW_DWIDTH-1:0] fifo_minval,
    input  logic [31:0]           fifo_position,
    input  logic [31:0]           fifo_qid,
    output logic [AXI_DWIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic                  busy,
    output logic [31:0]           results_sent
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        POP      = 3'd1,
        LATCH    = 3'd2,
        BEAT_QID = 3'd3,
        BEAT_POS = 3'd4,
        BEAT_MIN = 3'd5
    } state_t;

    state_t state_reg;
    state_t state_next;

    // Captured record; only loaded in LATCH so FIFO outputs are ignored
    // at every other time.
    logic [31:0]           qid_reg;
    logic [31:0]           pos_reg;
    logic [DTW_DWIDTH-1:0] min_reg;

    logic [31:0] results_sent_reg;
    logic [31:0] results_sent_next;

    logic [31:0] min_ext;
    logic        last_handshake;

    // -----------------------------------------------------------------------
    // Zero extension of the captured minimum cost to a full 32-bit word.
    // -----------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < 32; gi++) begin : g_min_ext
            if (gi < DTW_DWIDTH) begin : g_bit
                assign min_ext[gi] = min_reg[gi];
            end else begin : g_zero
                assign min_ext[gi] = 1'b0;
            end
        end
    endgenerate

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state and output decode. Outputs are pure functions of the state
    // and the captured registers, so tdata/tlast cannot change while a beat
    // is waiting for tready.
    // -----------------------------------------------------------------------
    always_comb begin
        state_next    = state_reg;
        fifo_rden     = 1'b0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        m_axis_tdata  = '0;
        busy          = 1'b1;

        case (state_reg)
            IDLE: begin
                busy = 1'b0;
                if (enable && !fifo_empty) begin
                    state_next = POP;
                end
            end

            POP: begin
                fifo_rden  = 1'b1;
                state_next = LATCH;
            end

            LATCH: begin
                // FIFO read data is valid in this cycle.
                state_next = BEAT_QID;
            end

            BEAT_QID: begin
                m_axis_tvalid = 1'b1;
                m_axis_tdata  = AXI_DWIDTH'(qid_reg);
                if (m_axis_tready) begin
                    state_next = BEAT_POS;
                end
            end

            BEAT_POS: begin
                m_axis_tvalid = 1'b1;
                m_axis_tdata  = AXI_DWIDTH'(pos_reg);
                if (m_axis_tready) begin
                    state_next = BEAT_MIN;
                end
            end

            BEAT_MIN: begin
                m_axis_tvalid = 1'b1;
                m_axis_tlast  = 1'b1;
                m_axis_tdata  = AXI_DWIDTH'(min_ext);
                if (m_axis_tready) begin
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Record capture
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            qid_reg <= '0;
            pos_reg <= '0;
            min_reg <= '0;
        end else if (state_reg == LATCH) begin
            qid_reg <= fifo_qid;
            pos_reg <= fifo_position;
            min_reg <= fifo_minval;
        end
    end

    // -----------------------------------------------------------------------
    // Completed-packet counter. Clear has priority over the increment; the
    // increment wraps naturally at the top of the 32-bit range.
    // -----------------------------------------------------------------------
    assign last_handshake = (state_reg == BEAT_MIN) && m_axis_tready;

    always_comb begin
        results_sent_next = results_sent_reg;
        if (clear_count) begin
            results_sent_next = '0;
        end else if (last_handshake) begin
            results_sent_next = results_sent_reg + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            results_sent_reg <= '0;
        end else begin
            results_sent_reg <= results_sent_next;
        end
    end

    assign results_sent = results_sent_reg;

endmodule

// File: tb/tb_dtw_result_streamer.sv
// ---------------------------------------------------------------------------
// tb_dtw_result_streamer
//
// Directed testbench for dtw_result_streamer. A small behavioural FIFO with
// one-cycle read latency feeds the DUT; outside a pop its data outputs carry
// random values so the DUT must capture only in the right cycle. A monitor
// logs every stream handshake and every FIFO pop. Inputs change and outputs
// are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_dtw_result_streamer;

    localparam int DW = 16;
    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          enable = 1'b0;
    logic          clear_count = 1'b0;
    logic          fifo_rden;
    logic          fifo_empty;
    logic [DW-1:0] fifo_minval = '0;
    logic [31:0]   fifo_position = '0;
    logic [31:0]   fifo_qid = '0;
    logic [AW-1:0] m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tready = 1'b0;
    logic          m_axis_tlast;
    logic          busy;
    logic [31:0]   results_sent;

    int n_checks = 0;
    int n_fail   = 0;

    dtw_result_streamer #(
        .DTW_DWIDTH(DW),
        .AXI_DWIDTH(AW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .clear_count  (clear_count),
        .fifo_rden    (fifo_rden),
        .fifo_empty   (fifo_empty),
        .fifo_minval  (fifo_minval),
        .fifo_position(fifo_position),
        .fifo_qid     (fifo_qid),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .m_axis_tlast (m_axis_tlast),
        .busy         (busy),
        .results_sent (results_sent)
    );

    always #5 clk = ~clk;

    // ---------------- FIFO model ----------------
    logic [31:0]   mem_qid [16];
    logic [31:0]   mem_pos [16];
    logic [DW-1:0] mem_min [16];
    int wr_ptr = 0;
    int rd_ptr = 0;

    assign fifo_empty = (rd_ptr == wr_ptr);

    always @(posedge clk) begin
        if (fifo_rden && (rd_ptr != wr_ptr)) begin
            fifo_qid      <= mem_qid[rd_ptr % 16];
            fifo_position <= mem_pos[rd_ptr % 16];
            fifo_minval   <= mem_min[rd_ptr % 16];
            rd_ptr        <= rd_ptr + 1;
        end else begin
            fifo_qid      <= $urandom;
            fifo_position <= $urandom;
            fifo_minval   <= DW'($urandom);
        end
    end

    // ---------------- Monitor ----------------
    int          cyc = 0;
    int          beat_n = 0;
    int          rden_n = 0;
    logic [31:0] beat_data [128];
    logic        beat_last [128];
    int          pop_cyc [64];

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (m_axis_tvalid && m_axis_tready) begin
            if (beat_n < 128) begin
                beat_data[beat_n] = m_axis_tdata;
                beat_last[beat_n] = m_axis_tlast;
            end
            $display("beat %0d: tdata=%08h tlast=%0b cycle=%0d", beat_n, m_axis_tdata, m_axis_tlast, cyc);
            beat_n = beat_n + 1;
        end
        if (fifo_rden) begin
            if (rden_n < 64) pop_cyc[rden_n] = cyc;
            $display("pop %0d: cycle=%0d", rden_n, cyc);
            rden_n = rden_n + 1;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- Helpers (stimulus only) ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic push(input logic [31:0] q, input logic [31:0] p, input logic [DW-1:0] m);
        mem_qid[wr_ptr % 16] = q;
        mem_pos[wr_ptr % 16] = p;
        mem_min[wr_ptr % 16] = m;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic wait_beats(input int target, input int budget, output bit ok);
        for (int i = 0; i < budget && beat_n < target; i++) tick();
        ok = (beat_n >= target);
    endtask

    task automatic pulse_clear();
        clear_count = 1'b1;
        tick();
        clear_count = 1'b0;
    endtask

    // ---------------- Tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        tick(); tick(); tick();
        n_checks++; if (m_axis_tvalid !== 1'b0) begin n_fail++; $display("FAIL reset_tvalid: got %b want 0", m_axis_tvalid); end
        n_checks++; if (fifo_rden !== 1'b0) begin n_fail++; $display("FAIL reset_rden: got %b want 0", fifo_rden); end
        n_checks++; if (m_axis_tlast !== 1'b0) begin n_fail++; $display("FAIL reset_tlast: got %b want 0", m_axis_tlast); end
        n_checks++; if (m_axis_tdata !== 32'h0) begin n_fail++; $display("FAIL reset_tdata: got %h want 0", m_axis_tdata); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (results_sent !== 32'h0) begin n_fail++; $display("FAIL reset_count: got %h want 0", results_sent); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single();
        int rb, bb;
        bit ok;
        logic [31:0] exp_d [3];
        exp_d[0] = 32'd7; exp_d[1] = 32'd1234; exp_d[2] = 32'h0000_00AB;
        pulse_clear();
        rb = rden_n; bb = beat_n;
        push(32'd7, 32'd1234, 16'h00AB);
        enable = 1'b1; m_axis_tready = 1'b1;
        wait_beats(bb + 3, 20, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL single_timeout: beats %0d want %0d", beat_n - bb, 3); end
        for (int k = 0; k < 3; k++) begin
            n_checks++; if (beat_data[bb+k] !== exp_d[k]) begin n_fail++; $display("FAIL single_data%0d: got %h want %h", k, beat_data[bb+k], exp_d[k]); end
            n_checks++; if (beat_last[bb+k] !== (k == 2)) begin n_fail++; $display("FAIL single_last%0d: got %b want %b", k, beat_last[bb+k], (k == 2)); end
        end
        tick();
        n_checks++; if (rden_n - rb !== 1) begin n_fail++; $display("FAIL single_rden: got %0d want 1", rden_n - rb); end
        n_checks++; if (results_sent !== 32'd1) begin n_fail++; $display("FAIL single_count: got %0d want 1", results_sent); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy: got %b want 0", busy); end
    endtask

    task automatic test_backpressure();
        int rb, bb;
        logic [31:0] exp_d [3];
        exp_d[0] = 32'd7; exp_d[1] = 32'd1234; exp_d[2] = 32'h0000_00AB;
        pulse_clear();
        m_axis_tready = 1'b0;
        rb = rden_n; bb = beat_n;
        push(32'd7, 32'd1234, 16'h00AB);
        enable = 1'b1;
        for (int i = 0; i < 20 && m_axis_tvalid !== 1'b1; i++) tick();
        for (int k = 0; k < 3; k++) begin
            for (int c = 0; c < 5; c++) begin
                n_checks++; if (m_axis_tvalid !== 1'b1) begin n_fail++; $display("FAIL bp_tvalid b%0d c%0d: got %b want 1", k, c, m_axis_tvalid); end
                n_checks++; if (m_axis_tdata !== exp_d[k]) begin n_fail++; $display("FAIL bp_tdata b%0d c%0d: got %h want %h", k, c, m_axis_tdata, exp_d[k]); end
                n_checks++; if (m_axis_tlast !== (k == 2)) begin n_fail++; $display("FAIL bp_tlast b%0d c%0d: got %b want %b", k, c, m_axis_tlast, (k == 2)); end
                tick();
            end
            m_axis_tready = 1'b1;
            tick();
            m_axis_tready = 1'b0;
        end
        n_checks++; if (beat_n - bb !== 3) begin n_fail++; $display("FAIL bp_beats: got %0d want 3", beat_n - bb); end
        for (int k = 0; k < 3; k++) begin
            n_checks++; if (beat_data[bb+k] !== exp_d[k]) begin n_fail++; $display("FAIL bp_logged%0d: got %h want %h", k, beat_data[bb+k], exp_d[k]); end
        end
        n_checks++; if (rden_n - rb !== 1) begin n_fail++; $display("FAIL bp_rden: got %0d want 1", rden_n - rb); end
        n_checks++; if (results_sent !== 32'd1) begin n_fail++; $display("FAIL bp_count: got %0d want 1", results_sent); end
        m_axis_tready = 1'b1;
    endtask

    task automatic test_back_to_back();
        int rb, bb;
        bit ok;
        logic [31:0] exp_d [9];
        exp_d[0] = 32'd1; exp_d[1] = 32'd100; exp_d[2] = 32'h0000_0011;
        exp_d[3] = 32'd2; exp_d[4] = 32'd200; exp_d[5] = 32'h0000_0022;
        exp_d[6] = 32'd3; exp_d[7] = 32'd300; exp_d[8] = 32'h0000_FFFF;
        enable = 1'b0;
        m_axis_tready = 1'b1;
        pulse_clear();
        push(32'd1, 32'd100, 16'h0011);
        push(32'd2, 32'd200, 16'h0022);
        push(32'd3, 32'd300, 16'hFFFF);
        rb = rden_n; bb = beat_n;
        enable = 1'b1;
        wait_beats(bb + 9, 60, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL b2b_timeout: beats %0d want 9", beat_n - bb); end
        for (int k = 0; k < 9; k++) begin
            n_checks++; if (beat_data[bb+k] !== exp_d[k]) begin n_fail++; $display("FAIL b2b_data%0d: got %h want %h", k, beat_data[bb+k], exp_d[k]); end
            n_checks++; if (beat_last[bb+k] !== (k % 3 == 2)) begin n_fail++; $display("FAIL b2b_last%0d: got %b want %b", k, beat_last[bb+k], (k % 3 == 2)); end
        end
        tick();
        n_checks++; if (rden_n - rb !== 3) begin n_fail++; $display("FAIL b2b_rden: got %0d want 3", rden_n - rb); end
        n_checks++; if (pop_cyc[rb+1] - pop_cyc[rb] !== 6) begin n_fail++; $display("FAIL b2b_gap1: got %0d want 6", pop_cyc[rb+1] - pop_cyc[rb]); end
        n_checks++; if (pop_cyc[rb+2] - pop_cyc[rb+1] !== 6) begin n_fail++; $display("FAIL b2b_gap2: got %0d want 6", pop_cyc[rb+2] - pop_cyc[rb+1]); end
        n_checks++; if (results_sent !== 32'd3) begin n_fail++; $display("FAIL b2b_count: got %0d want 3", results_sent); end
    endtask

    task automatic test_gating();
        int rb, bb;
        bit ok;
        enable = 1'b0;
        m_axis_tready = 1'b1;
        pulse_clear();
        rb = rden_n; bb = beat_n;
        push(32'h10, 32'h1000, 16'h0100);
        push(32'h20, 32'h2000, 16'h0200);
        for (int c = 0; c < 6; c++) begin
            tick();
            n_checks++; if (fifo_rden !== 1'b0) begin n_fail++; $display("FAIL gate_rden c%0d: got %b want 0", c, fifo_rden); end
            n_checks++; if (m_axis_tvalid !== 1'b0) begin n_fail++; $display("FAIL gate_tvalid c%0d: got %b want 0", c, m_axis_tvalid); end
        end
        enable = 1'b1;
        wait_beats(bb + 1, 20, ok);
        n_checks++; if (m_axis_tdata !== 32'h1000) begin n_fail++; $display("FAIL gate_in_pos: got %h want 00001000", m_axis_tdata); end
        enable = 1'b0;
        wait_beats(bb + 3, 20, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL gate_complete: beats %0d want 3", beat_n - bb); end
        n_checks++; if (beat_data[bb+2] !== 32'h0000_0100) begin n_fail++; $display("FAIL gate_min: got %h want 00000100", beat_data[bb+2]); end
        for (int c = 0; c < 10; c++) tick();
        n_checks++; if (rden_n - rb !== 1) begin n_fail++; $display("FAIL gate_rden_total: got %0d want 1", rden_n - rb); end
        n_checks++; if (beat_n - bb !== 3) begin n_fail++; $display("FAIL gate_beats_total: got %0d want 3", beat_n - bb); end
        n_checks++; if (results_sent !== 32'd1) begin n_fail++; $display("FAIL gate_count: got %0d want 1", results_sent); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL gate_busy: got %b want 0", busy); end
    endtask

    task automatic test_reset_mid_packet();
        int rb, bb;
        bit ok;
        rb = rden_n; bb = beat_n;
        m_axis_tready = 1'b1;
        enable = 1'b1;                     // record 0x20 is still queued
        wait_beats(bb + 1, 20, ok);
        n_checks++; if (m_axis_tdata !== 32'h2000) begin n_fail++; $display("FAIL rstmid_in_pos: got %h want 00002000", m_axis_tdata); end
        rst = 1'b1;
        m_axis_tready = 1'b0;
        tick();
        n_checks++; if (m_axis_tvalid !== 1'b0) begin n_fail++; $display("FAIL rstmid_tvalid: got %b want 0", m_axis_tvalid); end
        n_checks++; if (results_sent !== 32'd0) begin n_fail++; $display("FAIL rstmid_count: got %0d want 0", results_sent); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b want 0", busy); end
        n_checks++; if (m_axis_tdata !== 32'h0) begin n_fail++; $display("FAIL rstmid_tdata: got %h want 0", m_axis_tdata); end
        tick();
        rst = 1'b0;
        tick(); tick();
        n_checks++; if (beat_n - bb !== 1) begin n_fail++; $display("FAIL rstmid_no_more_beats: got %0d want 1", beat_n - bb); end
        bb = beat_n;
        push(32'h33, 32'h3333, 16'h0033);
        m_axis_tready = 1'b1;
        wait_beats(bb + 3, 20, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL rstmid_timeout: beats %0d want 3", beat_n - bb); end
        n_checks++; if (beat_data[bb] !== 32'h33) begin n_fail++; $display("FAIL rstmid_qid: got %h want 00000033", beat_data[bb]); end
        n_checks++; if (beat_data[bb+1] !== 32'h3333) begin n_fail++; $display("FAIL rstmid_pos: got %h want 00003333", beat_data[bb+1]); end
        n_checks++; if (beat_data[bb+2] !== 32'h33) begin n_fail++; $display("FAIL rstmid_min: got %h want 00000033", beat_data[bb+2]); end
        n_checks++; if (beat_last[bb+2] !== 1'b1) begin n_fail++; $display("FAIL rstmid_last: got %b want 1", beat_last[bb+2]); end
        tick();
        n_checks++; if (results_sent !== 32'd1) begin n_fail++; $display("FAIL rstmid_count_after: got %0d want 1", results_sent); end
        n_checks++; if (rden_n - rb !== 2) begin n_fail++; $display("FAIL rstmid_rden: got %0d want 2", rden_n - rb); end
    endtask

    task automatic test_counter();
        int bb;
        bit ok;
        enable = 1'b1;
        m_axis_tready = 1'b1;
        force dut.results_sent_next = 32'hFFFF_FFFF;
        tick();
        release dut.results_sent_next;
        tick();
        n_checks++; if (results_sent !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL cnt_preload: got %h want ffffffff", results_sent); end
        bb = beat_n;
        push(32'd1, 32'd2, 16'h0003);
        wait_beats(bb + 3, 20, ok);
        tick();
        n_checks++; if (results_sent !== 32'd0) begin n_fail++; $display("FAIL cnt_wrap: got %h want 0", results_sent); end
        bb = beat_n;
        push(32'd4, 32'd5, 16'h0006);
        wait_beats(bb + 3, 20, ok);
        tick();
        n_checks++; if (results_sent !== 32'd1) begin n_fail++; $display("FAIL cnt_incr: got %0d want 1", results_sent); end
        m_axis_tready = 1'b0;
        bb = beat_n;
        push(32'd7, 32'd8, 16'h0009);
        for (int i = 0; i < 20 && m_axis_tvalid !== 1'b1; i++) tick();
        m_axis_tready = 1'b1;
        tick(); tick();                    // QID and POS handshakes
        m_axis_tready = 1'b0;
        n_checks++; if (m_axis_tlast !== 1'b1) begin n_fail++; $display("FAIL cnt_at_min: tlast %b want 1", m_axis_tlast); end
        m_axis_tready = 1'b1;
        clear_count = 1'b1;
        tick();
        clear_count = 1'b0;
        n_checks++; if (results_sent !== 32'd0) begin n_fail++; $display("FAIL cnt_clear_wins: got %0d want 0", results_sent); end
        n_checks++; if (beat_n - bb !== 3) begin n_fail++; $display("FAIL cnt_clear_beats: got %0d want 3", beat_n - bb); end
        n_checks++; if (m_axis_tvalid !== 1'b0) begin n_fail++; $display("FAIL cnt_idle: tvalid %b want 0", m_axis_tvalid); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_back_to_back();
        test_gating();
        test_reset_mid_packet();
        test_counter();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dtw_result_streamer.md
DTW_RESULT_STREAMER -- requirements
Module: dtw_result_streamer

Interface
REQ-001 SHALL have parameter DTW_DWIDTH, default 16, width of the minval field.
REQ-002 SHALL have parameter AXI_DWIDTH, default 32, output stream word width; only 32 is supported.
REQ-003 SHALL have port clk, input, 1, clock; all logic on rising edge.
REQ-004 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-005 SHALL have port enable, input, 1, permits new FIFO pops when high.
REQ-006 SHALL have port clear_count, input, 1, synchronous clear of results_sent.
REQ-007 SHALL have port fifo_rden, output, 1, result FIFO read strobe.
REQ-008 SHALL have port fifo_empty, input, 1, result FIFO empty flag.
REQ-009 SHALL have port fifo_minval, input, DTW_DWIDTH, popped DTW minimum cost.
REQ-010 SHALL have port fifo_position, input, 32, popped reference position.
REQ-011 SHALL have port fifo_qid, input, 32, popped query id.
REQ-012 SHALL have port m_axis_tdata, output, AXI_DWIDTH, stream data.
REQ-013 SHALL have port m_axis_tvalid, output, 1, stream valid.
REQ-014 SHALL have port m_axis_tready, input, 1, stream ready.
REQ-015 SHALL have port m_axis_tlast, output, 1, last beat of a result packet.
REQ-016 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-017 SHALL have port results_sent, output, 32, count of completed packets.

Function
REQ-018 SHALL implement FSM states: IDLE, POP, LATCH, BEAT_QID, BEAT_POS, BEAT_MIN.
REQ-019 IDLE -> POP when enable=1 and fifo_empty=0; otherwise SHALL remain in IDLE.
REQ-020 fifo_rden SHALL be high for exactly one cycle, the cycle the FSM is in POP; it SHALL never be asserted in any other state.
REQ-021 POP -> LATCH unconditionally; FIFO read data SHALL be valid in the LATCH cycle (one-cycle registered read latency).
REQ-022 In LATCH, the block SHALL capture qid, position and minval into internal registers, then go to BEAT_QID.
REQ-023 The BEAT_* states SHALL drive m_axis_tvalid=1, with m_axis_tdata = captured qid, position, and {zeros, minval} zero-extended to 32 bits, respectively.
REQ-024 m_axis_tlast SHALL be 1 only in BEAT_MIN.
REQ-025 Each BEAT_* state SHALL advance only on tvalid&&tready: QID -> POS -> MIN -> IDLE.
REQ-026 While tready=0, tdata and tlast SHALL hold stable and tvalid SHALL stay 1; a beat SHALL never be withdrawn.
REQ-027 The handshake in BEAT_MIN SHALL increment results_sent by 1; at 32'hFFFFFFFF it SHALL wrap to 0.
REQ-028 clear_count=1 SHALL set results_sent to 0 next cycle; when it coincides with an increment, the clear SHALL win.
REQ-029 Deasserting enable mid-packet SHALL NOT abort the packet; it only blocks the next IDLE -> POP.
REQ-030 Changes on fifo_empty or the fifo data inputs outside the LATCH cycle SHALL have no effect.
REQ-031 Minimum spacing between packet starts SHALL be 6 cycles with tready held at 1 (POP, LATCH, 3 beats, IDLE).

Reset
REQ-032 While rst=1: state SHALL be IDLE, fifo_rden=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, busy=0, results_sent=0, captured registers=0.
REQ-033 rst mid-packet SHALL drop the packet with no further beats; tvalid=0 from the cycle after rst is sampled, and no FIFO pop SHALL occur until rst is low and REQ-019 holds.

Verification
REQ-034 Single record: FIFO holds {qid=7, pos=1234, min=16'h00AB}, enable=1, tready=1 -> one rden pulse; beats 7, 1234, 32'h000000AB; tlast on beat 3 only; results_sent=1.
REQ-035 Backpressure: same record, tready low for 5 cycles at each beat -> each beat held stable with tvalid=1; no extra rden; results_sent=1 after the last handshake.
REQ-036 Back-to-back: 3 records queued, tready=1 -> 9 beats in order, packet starts 6 cycles apart, exactly 3 rden pulses, results_sent=3.
REQ-037 Gating: fifo_empty=0 with enable=0 -> no rden and tvalid=0; drop enable during BEAT_POS -> packet completes and no new pop follows.
REQ-038 Reset mid-packet: assert rst during BEAT_POS -> tvalid=0 the next cycle, results_sent=0; after release with a new record -> clean 3-beat packet.
REQ-039 Counter: force results_sent to 32'hFFFFFFFF and complete a packet -> 0; assert clear_count on the same cycle as a BEAT_MIN handshake -> 0.
